// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and small decode helpers used by both the instruction decoder and the unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_e;

    function automatic logic op_is_mul(input mdu_op_e o);
        return (o == MDU_MULT) || (o == MDU_MULTU);
    endfunction

    function automatic logic op_is_div(input mdu_op_e o);
        return (o == MDU_DIV) || (o == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e o);
        return (o == MDU_MULT) || (o == MDU_DIV);
    endfunction

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: load captures the
// operands, each step retires one quotient bit, MSB first.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH:0]   trial;

    // Partial remainder stays below the divisor, so bit WIDTH of the trial
    // difference is a clean borrow flag.
    assign trial = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, dvs_reg};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo_reg <= '0;
            rem_reg <= '0;
            dvs_reg <= '0;
        end else if (load) begin
            quo_reg <= dividend;
            rem_reg <= '0;
            dvs_reg <= divisor;
        end else if (step) begin
            if (!trial[WIDTH]) begin
                rem_reg <= trial[WIDTH-1:0];
                quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
            end else begin
                rem_reg <= {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
                quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: WIDTH-cycle shift-add multiply and
// restoring divide on magnitudes, followed by a one-cycle sign fix-up.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e         state_reg;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               dbz_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   ma_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic               neg_reg;
    logic               rneg_reg;
    logic               bzero_reg;
    logic               is_div_reg;

    mdu_op_e            op_e;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               accept;
    logic               div_load;
    logic               div_step;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_mag;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op_e      = mdu_op_e'(op);
    assign op_signed = op_is_signed(op_e);
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    // The most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    assign accept    = (state_reg == ST_IDLE) && start && !flush;
    assign div_load  = accept && op_is_div(op_e);
    assign div_step  = (state_reg == ST_DIV) && !flush;

    // Shift-add: upper half accumulates the multiplicand, lower half shifts out multiplier bits.
    assign mul_addend = prod_reg[0] ? ma_reg : '0;
    assign mul_sum    = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

    assign prod_fix = neg_reg  ? -prod_reg : prod_reg;
    assign quo_fix  = neg_reg  ? -quo_mag  : quo_mag;
    assign rem_fix  = rneg_reg ? -rem_mag  : rem_mag;

    div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .load     (div_load),
        .step     (div_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quotient (quo_mag),
        .remainder(rem_mag)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            ma_reg     <= '0;
            prod_reg   <= '0;
            neg_reg    <= 1'b0;
            rneg_reg   <= 1'b0;
            bzero_reg  <= 1'b0;
            is_div_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_e)
                            MDU_MULT, MDU_MULTU: begin
                                ma_reg     <= a_mag;
                                prod_reg   <= {{WIDTH{1'b0}}, b_mag};
                                neg_reg    <= a_neg ^ b_neg;
                                cnt_reg    <= '0;
                                is_div_reg <= 1'b0;
                                busy_reg   <= 1'b1;
                                state_reg  <= ST_MUL;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                neg_reg    <= a_neg ^ b_neg;
                                rneg_reg   <= a_neg;
                                bzero_reg  <= (b == '0);
                                cnt_reg    <= '0;
                                is_div_reg <= 1'b1;
                                busy_reg   <= 1'b1;
                                state_reg  <= ST_DIV;
                            end
                            MDU_MTHI: hi_reg <= a;
                            MDU_MTLO: lo_reg <= a;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        prod_reg <= {mul_sum, prod_reg[WIDTH-1:1]};
                        cnt_reg  <= cnt_reg + CW'(1);
                        if (cnt_reg == LAST) begin
                            state_reg <= ST_FIX;
                        end
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                        if (cnt_reg == LAST) begin
                            state_reg <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                    if (!flush) begin
                        done_reg <= 1'b1;
                        if (!is_div_reg) begin
                            {hi_reg, lo_reg} <= prod_fix;
                        end else if (bzero_reg) begin
                            dbz_reg <= 1'b1;
                        end else begin
                            hi_reg <= rem_fix;
                            lo_reg <= quo_fix;
                        end
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: hand-computed HI/LO results,
// latency, div-by-zero, MTHI/MTLO, flush and reset behaviour.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk = 1'b0;
    logic             resetn;
    logic             start;
    logic [2:0]       op;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_div_unit #(
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .op         (op),
        .flush      (flush),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Starts an iterative op, keeps start high with a junk MTLO while busy,
    // then checks latency, busy length, flag and HI/LO.
    task automatic run_iter(input string tag, input logic [2:0] o,
                            input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] ehi, input logic [31:0] elo,
                            input logic edbz);
        int   done_at  = -1;
        int   busy_cnt = 0;
        logic dbz_at   = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        for (int n = 0; n < 3 * LAT && done_at < 0; n++) begin
            @(negedge clk);
            if (n == 0) begin
                op = MDU_MTLO; a = 32'hDEADBEEF; b = 32'h0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_at = n;
                dbz_at  = div_by_zero;
                start   = 1'b0;
            end
        end
        start = 1'b0; op = MDU_NOP;
        check({tag, ".latency"}, 64'(done_at), 64'(LAT));
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(LAT));
        check({tag, ".dbz"}, 64'(dbz_at), 64'(edbz));
        check({tag, ".hi"}, 64'(hi), 64'(ehi));
        check({tag, ".lo"}, 64'(lo), 64'(elo));
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; op = o; a = v;
        @(negedge clk);
        start = 1'b0; op = MDU_NOP; a = 32'h0;
        if (o == MDU_MTHI) check("mthi", 64'(hi), 64'(v));
        else               check("mtlo", 64'(lo), 64'(v));
        check("mt.busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int seen;
        resetn = 1'b0; start = 1'b0; flush = 1'b0; op = MDU_NOP; a = '0; b = '0;
        #12;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.dbz",  64'(div_by_zero), 64'd0);
        check("rst.hi",   64'(hi), 64'd0);
        check("rst.lo",   64'(lo), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_iter("mult_m1x2",  MDU_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_iter("multu_m1x2", MDU_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1'b0);
        run_iter("mult_m3x5",  MDU_MULT,  32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_iter("mult_minsq", MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0);
        run_iter("multu_max",  MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0);
        run_iter("div_m7d2",   MDU_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_iter("div_7dm2",   MDU_DIV,   32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0);
        run_iter("div_min_m1", MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        run_iter("divu_100d7", MDU_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        mt(MDU_MTHI, 32'h1234);
        mt(MDU_MTLO, 32'h5678);
        run_iter("divu_by0",   MDU_DIVU,  32'h7, 32'h0, 32'h1234, 32'h5678, 1'b1);

        // NOP and reserved op with start: no effect
        @(negedge clk); start = 1'b1; op = MDU_NOP; a = 32'hFFFF;
        @(negedge clk); op = MDU_RSVD;
        @(negedge clk); start = 1'b0; op = MDU_NOP;
        check("nop.busy", 64'(busy), 64'd0);
        check("nop.hi", 64'(hi), 64'h1234);
        check("nop.lo", 64'(lo), 64'h5678);

        mt(MDU_MTHI, 32'h11);
        mt(MDU_MTLO, 32'h22);

        // flush together with start blocks an MTLO
        @(negedge clk); start = 1'b1; op = MDU_MTLO; a = 32'hDEAD; flush = 1'b1;
        @(negedge clk); start = 1'b0; op = MDU_NOP; flush = 1'b0;
        check("flush_idle.lo", 64'(lo), 64'h22);

        // flush a MULT in its tenth cycle
        @(negedge clk); start = 1'b1; op = MDU_MULT; a = 32'd7; b = 32'd9;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_mul.busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush_mul.busy_after", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || div_by_zero) seen++;
        end
        check("flush_mul.no_done", 64'(seen), 64'd0);
        check("flush_mul.hi", 64'(hi), 64'h11);
        check("flush_mul.lo", 64'(lo), 64'h22);

        // flush a DIV while it sits in the fix-up cycle
        @(negedge clk); start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (32) @(negedge clk);
        check("flush_fix.busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        seen = (done || div_by_zero) ? 1 : 0;
        check("flush_fix.busy_after", 64'(busy), 64'd0);
        repeat (5) begin
            @(negedge clk);
            if (done || div_by_zero) seen++;
        end
        check("flush_fix.no_done", 64'(seen), 64'd0);
        check("flush_fix.hi", 64'(hi), 64'h11);
        check("flush_fix.lo", 64'(lo), 64'h22);

        // asynchronous reset in the middle of a DIV
        @(negedge clk); start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        check("rst_mid.busy_before", 64'(busy), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid.busy", 64'(busy), 64'd0);
        check("rst_mid.done", 64'(done), 64'd0);
        check("rst_mid.dbz",  64'(div_by_zero), 64'd0);
        check("rst_mid.hi",   64'(hi), 64'd0);
        check("rst_mid.lo",   64'(lo), 64'd0);
        @(negedge clk); resetn = 1'b1;
        mt(MDU_MTLO, 32'hA5);
        check("rst_mid.hi_after", 64'(hi), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand, HI and LO width; legal values are 8, 16, 32 and 64.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request qualifier; sampled only while busy=0.
REQ-005 op  input  3  operation: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP).
REQ-006 flush  input  1  pipeline flush; aborts any operation in flight.
REQ-007 a, b  input  WIDTH  operands (a = multiplicand/dividend/MTxx source, b = multiplier/divisor).
REQ-008 busy  output  1  high while an iterative operation is in flight; the pipeline stalls on it.
REQ-009 done  output  1  one-cycle pulse on the cycle HI/LO first show a MULT/MULTU/DIV/DIVU result.
REQ-010 div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with b=0.
REQ-011 hi, lo  output  WIDTH  architectural HI and LO registers, driven directly from flops.

Function
REQ-012 States SHALL be IDLE, MUL, DIV and FIX; busy=1 exactly in MUL, DIV and FIX.
REQ-013 In IDLE, start=1 with MULT/MULTU SHALL latch a, b and the signedness, clear the iteration counter, and go to MUL.
REQ-014 In IDLE, start=1 with DIV/DIVU SHALL latch a, b and the signedness, clear the iteration counter, and go to DIV.
REQ-015 MUL and DIV SHALL each run exactly WIDTH iterations (one radix-2 shift-add or restoring-subtract step per cycle) on operand magnitudes, then go to FIX.
REQ-016 FIX SHALL apply sign correction, write HI/LO, assert done, and return to IDLE; a start in the same cycle is ignored.
REQ-017 Latency: start is sampled at edge 0; done=1 and HI/LO are valid in the cycle after edge WIDTH+1; a new start is accepted from the following cycle.
REQ-018 MULT/MULTU SHALL write {hi,lo} = 2*WIDTH-bit signed/unsigned product.
REQ-019 DIV/DIVU SHALL write lo = quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-020 DIV of the most-negative value by -1 SHALL give lo = most-negative value and hi = 0, with no flag.
REQ-021 DIV/DIVU with b=0 SHALL still take the full latency, leave HI/LO unchanged, and pulse div_by_zero with done.
REQ-022 MTHI/MTLO with start=1 in IDLE SHALL write a into hi/lo at the next edge, with busy=0 and no done pulse.
REQ-023 NOP/reserved op with start=1 SHALL have no effect.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 a, b and op changes after acceptance SHALL not affect the result.
REQ-026 flush=1 in any busy state SHALL force IDLE at the next edge: HI/LO unchanged, no done, no div_by_zero.
REQ-027 flush=1 together with start in IDLE SHALL block acceptance, including MTHI/MTLO.
REQ-028 flush=1 in FIX SHALL also suppress the HI/LO write and the done pulse.

Reset
REQ-029 resetn=0 SHALL immediately force: state IDLE, busy 0, done 0, div_by_zero 0, hi 0, lo 0, iteration counter 0.
REQ-030 Reset during an operation SHALL discard it; after resetn rises, the first edge with start=1 is accepted normally.

Structure
REQ-031 Package mdu_pkg SHALL hold the op encodings (MDU_NOP through MDU_MTLO) and the state encodings; the decoder and this block both use them.
REQ-032 The iterative restoring divider datapath SHALL be a sub-module div_core (inputs: magnitudes, step, load; outputs: quotient, remainder); the multiplier datapath stays inline.
REQ-033 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification (WIDTH=32)
REQ-034 MULT a=0xFFFFFFFF, b=0x00000002 -> done in the cycle after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high 33 cycles.
REQ-035 MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 DIVU a=7, b=0 after MTHI 0x1234 and MTLO 0x5678 -> div_by_zero and done pulse together; hi=0x1234, lo=0x5678.
REQ-038 MULT started, flush at cycle 10 -> busy=0 at cycle 11, no done, HI/LO unchanged.
REQ-039 resetn dropped mid-DIV -> all outputs 0 immediately; a following MTLO 0xA5 gives lo=0xA5 one edge later.
